// File: rtl/step_motor_ctrl.sv
// Command-driven two-phase stepper sequencer.
// Takes a move command (direction, step count, step period) over a valid/ready
// handshake, paces steps with an internal divider, walks a 2-bit phase index and
// drives one coil at a time. Every output comes straight from a flop.
module step_motor_ctrl #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter bit HOLD  = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_DIR,
    input  logic [CNT_W-1:0] CMD_STEPS,
    input  logic [DIV_W-1:0] CMD_PERIOD,
    input  logic             ABORT,
    output logic             A,
    output logic             AN,
    output logic             B,
    output logic             BN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ABORTED,
    output logic [CNT_W-1:0] STEPS_LEFT
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state,      state_n;
    logic [1:0]         phase,      phase_n;
    logic               energised,  energised_n;
    logic [CNT_W-1:0]   steps_n;
    logic [DIV_W-1:0]   divider,    divider_n;
    logic [DIV_W-1:0]   period_lat, period_n;
    logic               dir_lat,    dir_n;
    logic               done_n;
    logic               aborted_n;
    logic               drive_n;
    logic [3:0]         coils_n;

    // A period of zero behaves like one, so the reload value is period-1 with 0 clamped to 0.
    function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] p);
        return (p == '0) ? '0 : p - DIV_W'(1);
    endfunction

    // Next-state logic: command acceptance, step pacing, abort handling and the
    // registered-output values that go with them.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        energised_n = energised;
        steps_n     = STEPS_LEFT;
        divider_n   = divider;
        period_n    = period_lat;
        dir_n       = dir_lat;
        done_n      = 1'b0;
        aborted_n   = 1'b0;

        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    dir_n    = CMD_DIR;
                    period_n = CMD_PERIOD;
                    if (CMD_STEPS == '0) begin
                        // Zero-length move completes immediately without touching the coils.
                        done_n = 1'b1;
                    end else begin
                        state_n     = RUN;
                        steps_n     = CMD_STEPS;
                        divider_n   = reload_of(CMD_PERIOD);
                        energised_n = 1'b1;
                    end
                end
            end

            RUN: begin
                if (ABORT) begin
                    // Abort wins over a coincident step: phase and count freeze where they are.
                    state_n   = IDLE;
                    aborted_n = 1'b1;
                end else if (divider != '0) begin
                    divider_n = divider - DIV_W'(1);
                end else begin
                    phase_n   = dir_lat ? (phase - 2'd1) : (phase + 2'd1);
                    divider_n = reload_of(period_lat);
                    if (STEPS_LEFT <= CNT_W'(1)) begin
                        steps_n = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        steps_n = STEPS_LEFT - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Coils follow the phase being entered so the final step shows in the DONE cycle.
        drive_n = (state_n == RUN) || (HOLD && energised_n);
        coils_n = drive_n ? (4'b0001 << phase_n) : 4'b0000;
    end

    // State and output registers; reset is synchronous and clears any move in flight silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            phase      <= 2'd0;
            energised  <= 1'b0;
            STEPS_LEFT <= '0;
            divider    <= '0;
            period_lat <= '0;
            dir_lat    <= 1'b0;
            A          <= 1'b0;
            AN         <= 1'b0;
            B          <= 1'b0;
            BN         <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ABORTED    <= 1'b0;
            CMD_READY  <= 1'b1;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            energised  <= energised_n;
            STEPS_LEFT <= steps_n;
            divider    <= divider_n;
            period_lat <= period_n;
            dir_lat    <= dir_n;
            A          <= coils_n[0];
            AN         <= coils_n[1];
            B          <= coils_n[2];
            BN         <= coils_n[3];
            BUSY       <= (state_n == RUN);
            DONE       <= done_n;
            ABORTED    <= aborted_n;
            CMD_READY  <= (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Self-checking bench for step_motor_ctrl: directed moves followed by random
// command/abort/reset traffic, compared each cycle against a schedule-based model.
module tb_step_motor_ctrl;

    localparam int CNT_W = 8;
    localparam int DIV_W = 4;
    localparam bit HOLD  = 1'b1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic             CMD_DIR;
    logic [CNT_W-1:0] CMD_STEPS;
    logic [DIV_W-1:0] CMD_PERIOD;
    logic             ABORT;
    logic             A, AN, B, BN;
    logic             BUSY, DONE, ABORTED;
    logic [CNT_W-1:0] STEPS_LEFT;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    // Reference model: a move is a list of step instants accept+k*P, not a divider.
    bit modelRun, modelEnergised, modelDir, modelDone, modelAborted;
    int modelPhase, modelSteps, modelPeriod, modelNextStep;

    step_motor_ctrl #(
        .CNT_W (CNT_W),
        .DIV_W (DIV_W),
        .HOLD  (HOLD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_DIR    (CMD_DIR),
        .CMD_STEPS  (CMD_STEPS),
        .CMD_PERIOD (CMD_PERIOD),
        .ABORT      (ABORT),
        .A          (A),
        .AN         (AN),
        .B          (B),
        .BN         (BN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ABORTED    (ABORTED),
        .STEPS_LEFT (STEPS_LEFT)
    );

    always #5 CLK = ~CLK;

    // Hard stop in case something outside the bounded loops stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Advance the model by one clock edge using the inputs the bench is driving.
    task automatic modelEdge();
        if (RST) begin
            modelRun = 0; modelEnergised = 0; modelDone = 0; modelAborted = 0;
            modelPhase = 0; modelSteps = 0;
        end else if (!modelRun) begin
            modelDone = 0; modelAborted = 0;
            if (CMD_VALID) begin
                if (CMD_STEPS == 0) begin
                    modelDone = 1;
                end else begin
                    modelRun       = 1;
                    modelEnergised = 1;
                    modelDir       = CMD_DIR;
                    modelSteps     = int'(CMD_STEPS);
                    modelPeriod    = (CMD_PERIOD == 0) ? 1 : int'(CMD_PERIOD);
                    modelNextStep  = cycle + modelPeriod;
                end
            end
        end else begin
            modelDone = 0; modelAborted = 0;
            if (ABORT) begin
                modelRun     = 0;
                modelAborted = 1;
            end else if (cycle == modelNextStep) begin
                modelPhase    = modelDir ? (modelPhase + 3) % 4 : (modelPhase + 1) % 4;
                modelSteps    = modelSteps - 1;
                modelNextStep = modelNextStep + modelPeriod;
                if (modelSteps == 0) begin
                    modelRun  = 0;
                    modelDone = 1;
                end
            end
        end
    endtask

    task automatic checkAll();
        int coils;
        coils = (modelRun || (HOLD && modelEnergised)) ? (1 << modelPhase) : 0;
        checkOutput("coils",      {28'd0, BN, B, AN, A}, coils);
        checkOutput("busy",       {31'd0, BUSY},         {31'd0, modelRun});
        checkOutput("cmd_ready",  {31'd0, CMD_READY},    {31'd0, !modelRun});
        checkOutput("done",       {31'd0, DONE},         {31'd0, modelDone});
        checkOutput("aborted",    {31'd0, ABORTED},      {31'd0, modelAborted});
        checkOutput("steps_left", {24'd0, STEPS_LEFT},   modelSteps);
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare 1 time unit later.
    task automatic applyStimulus(input bit rst, input bit valid, input bit dir,
                                 input int steps, input int period, input bit abort);
        RST        = rst;
        CMD_VALID  = valid;
        CMD_DIR    = dir;
        CMD_STEPS  = steps[CNT_W-1:0];
        CMD_PERIOD = period[DIV_W-1:0];
        ABORT      = abort;
        @(posedge CLK);
        cycle++;
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic runMove(input bit dir, input int steps, input int period);
        applyStimulus(0, 1, dir, steps, period, 0);
        for (int i = 0; i < 400 && modelRun; i++) idleCycles(1);
        idleCycles(2);
    endtask

    initial begin
        RST = 1; CMD_VALID = 0; CMD_DIR = 0; CMD_STEPS = '0; CMD_PERIOD = '0; ABORT = 0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 5, 1, 1);
        idleCycles(2);

        // Forward 4 steps every 3 cycles, then reverse 3 single-cycle steps.
        runMove(0, 4, 3);
        runMove(1, 3, 1);
        checkOutput("hold_an", {31'd0, AN}, 32'd1);

        // Period 0 acts like period 1; zero-step move only pulses DONE.
        runMove(0, 2, 0);
        runMove(0, 0, 3);

        // Abort on the third step edge of a 10-step, period-2 move.
        applyStimulus(0, 1, 0, 10, 2, 0);
        idleCycles(5);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("abort_steps_left", {24'd0, STEPS_LEFT}, 32'd8);
        idleCycles(3);

        // Reset in the middle of a move.
        applyStimulus(0, 1, 1, 6, 2, 0);
        idleCycles(3);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idleCycles(2);

        // Second command held valid throughout the first move, taken in the DONE cycle.
        applyStimulus(0, 1, 0, 3, 2, 0);
        for (int i = 0; i < 100 && modelRun; i++) applyStimulus(0, 1, 1, 2, 1, 0);
        applyStimulus(0, 1, 1, 2, 1, 0);
        for (int i = 0; i < 100 && modelRun; i++) idleCycles(1);
        idleCycles(2);

        // Largest period gives a step every 2^DIV_W-1 cycles.
        runMove(1, 2, (1 << DIV_W) - 1);

        // Random traffic including aborts, zero-length moves and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit rst, valid, dir, abort;
            int steps, period;
            rst    = ($urandom_range(0, 199) == 0);
            valid  = ($urandom_range(0, 3) == 0);
            dir    = 1'($urandom_range(0, 1));
            abort  = ($urandom_range(0, 39) == 0);
            steps  = int'($urandom_range(0, 5));
            period = ($urandom_range(0, 9) == 0) ? (1 << DIV_W) - 1 : int'($urandom_range(0, 4));
            applyStimulus(rst, valid, dir, steps, period, abort);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/step_motor_ctrl.md
Name: step_motor_ctrl

Overview:
Command-driven sequencer for the two-phase stepper drive (coil outputs A, AN, B, BN).
- Accepts a move command (direction, step count, step period) over a valid/ready handshake.
- Generates the step rate internally and advances a 2-bit phase index once per step period.
- Decodes the phase index to one-hot coil drive.
- Reports BUSY, DONE and ABORTED status to the front-panel/control logic.

Parameters:
CNT_W, 16, width of step count and steps-remaining counter
DIV_W, 16, width of step-period divider
HOLD, 1, 1 = keep last phase energised when idle; 0 = all coil outputs 0 when idle

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
CMD_VALID  input  1  command present
CMD_READY  output  1  controller can accept a command
CMD_DIR  input  1  0 = forward (phase +1), 1 = reverse (phase -1)
CMD_STEPS  input  CNT_W  number of steps to take
CMD_PERIOD  input  DIV_W  clock cycles per step; 0 is treated as 1
ABORT  input  1  stop current move
A  output  1  coil A drive
AN  output  1  coil A-bar drive
B  output  1  coil B drive
BN  output  1  coil B-bar drive
BUSY  output  1  move in progress
DONE  output  1  one-cycle pulse, move completed normally
ABORTED  output  1  one-cycle pulse, move terminated by ABORT
STEPS_LEFT  output  CNT_W  remaining steps of current move

Behaviour:
- One clock; reset is synchronous and active-high (CLK, RST).
- Reset, sampled on a CLK edge, sets:
  - state IDLE, phase 0, ENERGISED 0;
  - STEPS_LEFT 0, divider 0;
  - A/AN/B/BN all 0;
  - DONE, ABORTED, BUSY all 0;
  - CMD_READY 1 in the cycle after the reset edge.
- RST overrides all other inputs, including mid-move; no DONE or ABORTED is issued for the interrupted move.
- All outputs are driven from registers only. There is no combinational path from any input.
- Phase decode, one-hot:
  - index 0 -> A;
  - index 1 -> AN;
  - index 2 -> B;
  - index 3 -> BN.
  - Forward is index+1 mod 4 (3 wraps to 0); reverse is index-1 mod 4 (0 wraps to 3).
- Coil outputs:
  - Decoded phase is driven when state is RUN, or when state is IDLE with HOLD=1 and ENERGISED=1.
  - Otherwise all four coil outputs are 0.
- FSM states: IDLE, RUN.
- IDLE:
  - CMD_READY=1, BUSY=0.
  - Accept occurs on an edge where CMD_VALID=1. The accepting edge latches CMD_DIR, CMD_STEPS and CMD_PERIOD.
  - Accept with CMD_STEPS=0: stay IDLE; DONE=1 for the following cycle; phase and ENERGISED unchanged.
  - Accept with CMD_STEPS>0: go to RUN; STEPS_LEFT<=CMD_STEPS; divider<=max(CMD_PERIOD,1)-1; ENERGISED<=1.
- RUN:
  - CMD_READY=0, BUSY=1. CMD_VALID is ignored.
  - Each edge with divider!=0: divider decrements.
  - Edge with divider==0 (a step edge): phase advances per latched DIR, STEPS_LEFT decrements, divider reloads with max(PERIOD,1)-1.
  - Step edges therefore fall at accept+P, accept+2P, and so on, where P=max(PERIOD,1).
  - Step edge where STEPS_LEFT goes 1->0: go to IDLE; DONE=1 for one cycle. The final phase is visible in that same cycle.
  - ABORT=1 on any RUN edge: go to IDLE; ABORTED=1 for one cycle; STEPS_LEFT holds its value; phase holds.
  - If ABORT coincides with a step edge, ABORT wins: no phase advance, no decrement, no DONE.
- ABORT while IDLE is ignored.
- DONE and ABORTED are never high in the same cycle.
- Back-to-back moves: a command presented in the cycle DONE is high is accepted on that edge (CMD_READY is already 1). The phase continues from the final phase of the previous move.
- Widths:
  - Counters are unsigned. STEPS_LEFT never underflows.
  - A PERIOD of all ones gives a step every 2^DIV_W-1 cycles.

Test Plan:
- Reset, then CMD_STEPS=4, PERIOD=3, DIR=0 accepted at edge E0 -> A=1 after E0; AN after E3; B after E6; BN after E9; A after E12 with DONE=1 one cycle; BUSY high from E0 to E12; STEPS_LEFT 4,3,2,1,0.
- From phase 0, STEPS=3, PERIOD=1, DIR=1 -> one step per cycle; phases 3,2,1 (BN, B, AN); DONE after third edge. With HOLD=1, AN stays high while IDLE.
- PERIOD=0, STEPS=2 -> behaves identically to PERIOD=1; two consecutive step edges; DONE.
- STEPS=0 -> no RUN; BUSY stays 0; DONE pulses once; coil outputs unchanged (all 0 if never energised).
- STEPS=10, PERIOD=2; ABORT asserted on the 3rd step edge -> ABORTED=1 one cycle; STEPS_LEFT=8; phase reflects 2 steps; no DONE. Also: RST mid-move -> all outputs 0 and CMD_READY=1 next cycle.
- Second command held valid while in RUN -> ignored until DONE cycle, then accepted on that edge; the new move starts from the prior final phase.
